// File: rtl/swerv_types.sv
// Shared divider types: the control packet sent to exu_div_ctl and the
// request record buffered by the issue sequencer.
package swerv_types;

  localparam int DIV_XLEN  = 64;
  localparam int DIV_TAG_W = 5;

  typedef struct packed {
    logic valid;
    logic unsign;
    logic rem;
  } div_pkt_t;

  typedef struct packed {
    logic [DIV_XLEN-1:0]  dividend;
    logic [DIV_XLEN-1:0]  divisor;
    logic                 unsign;
    logic                 rem;
    logic [DIV_TAG_W-1:0] tag;
  } div_req_t;

endpackage

// File: rtl/div_req_fifo.sv
// Small circular request buffer for divide requests with synchronous clear.
module div_req_fifo
  import swerv_types::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  div_req_t         push_data_i,
  input  logic             pop_i,
  output div_req_t         head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  div_req_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/exu_div_issue_ctl.sv
// Initiator-side sequencer for exu_div_ctl: buffers requests, issues one at a
// time, holds operands while the divider runs, and returns result or timeout.
module exu_div_issue_ctl
  import swerv_types::*;
#(
  parameter int XLEN    = DIV_XLEN,   // must match the package record width
  parameter int DEPTH   = 2,
  parameter int TAG_W   = DIV_TAG_W,
  parameter int TIMEOUT = 128
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [XLEN-1:0]  req_dividend_i,
  input  logic [XLEN-1:0]  req_divisor_i,
  input  logic             req_unsign_i,
  input  logic             req_rem_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output div_pkt_t         div_dp_o,
  output logic [XLEN-1:0]  div_dividend_o,
  output logic [XLEN-1:0]  div_divisor_o,
  output logic             div_flush_o,
  input  logic             div_finish_i,
  input  logic [XLEN-1:0]  div_out_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [XLEN-1:0]  rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int FCNT_W = $clog2(DEPTH + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  div_req_t          hold_q, hold_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic              rsp_err_q, rsp_err_d;

  div_req_t          push_req, head;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full, fifo_empty, push, pop, timeout_abort, issue;

  assign push_req = '{dividend: req_dividend_i, divisor: req_divisor_i,
                      unsign: req_unsign_i, rem: req_rem_i, tag: req_tag_i};

  // No bypass: a full buffer refuses requests even while it is being popped.
  assign req_ready_o = ~fifo_full & ~flush_i & ~rst_i;
  assign push        = req_valid_i & req_ready_o;

  div_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (flush_i),
    .push_i      (push),
    .push_data_i (push_req),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    rsp_data_d    = rsp_data_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_err_d     = rsp_err_q;
    pop           = 1'b0;
    timeout_abort = 1'b0;
    unique case (state_q)
      S_IDLE: if (!fifo_empty) state_d = S_ISSUE;
      S_ISSUE: begin
        pop     = 1'b1;
        hold_d  = head;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (div_finish_i) begin
          rsp_data_d = div_out_i;
          rsp_tag_d  = hold_q.tag;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_abort = 1'b1;
          rsp_data_d    = '0;
          rsp_tag_d     = hold_q.tag;
          rsp_err_d     = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_RESP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Flush overrides finish, timeout and the response handshake.
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign issue       = (state_q == S_ISSUE);
  assign div_flush_o = flush_i | timeout_abort | rst_i;

  always_comb begin
    div_dp_o       = '0;
    div_dividend_o = '0;
    div_divisor_o  = '0;
    rsp_valid_o    = 1'b0;
    rsp_data_o     = '0;
    rsp_tag_o      = '0;
    rsp_err_o      = 1'b0;
    busy_o         = 1'b0;
    if (!rst_i) begin
      div_dp_o.valid  = issue;
      div_dp_o.unsign = issue ? head.unsign : hold_q.unsign;
      div_dp_o.rem    = issue ? head.rem : hold_q.rem;
      div_dividend_o  = issue ? head.dividend : hold_q.dividend;
      div_divisor_o   = issue ? head.divisor : hold_q.divisor;
      rsp_valid_o     = (state_q == S_RESP);
      rsp_data_o      = rsp_data_q;
      rsp_tag_o       = rsp_tag_q;
      rsp_err_o       = rsp_err_q;
      busy_o          = (state_q != S_IDLE) | (fifo_count != '0);
    end
  end

endmodule

// File: tb/tb_exu_div_issue_ctl.sv
// Scoreboard bench for exu_div_issue_ctl with a behavioural divider model.
module tb_exu_div_issue_ctl;
  import swerv_types::*;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  logic        clk, rst, flush;
  logic        req_valid, req_ready, req_unsign, req_rem;
  logic [63:0] req_dividend, req_divisor;
  logic [4:0]  req_tag;
  div_pkt_t    div_dp;
  logic [63:0] div_dividend, div_divisor, div_out, rsp_data;
  logic        div_flush, div_finish, rsp_valid, rsp_ready, rsp_err, busy;
  logic [4:0]  rsp_tag;

  int       n_cmp = 0;
  int       n_err = 0;
  int       div_lat = 4;
  exp_t     exp_q[$];
  div_req_t issue_q[$];

  exu_div_issue_ctl #(.XLEN(64), .DEPTH(2), .TAG_W(5), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_dividend_i(req_dividend), .req_divisor_i(req_divisor),
    .req_unsign_i(req_unsign), .req_rem_i(req_rem), .req_tag_i(req_tag),
    .div_dp_o(div_dp), .div_dividend_o(div_dividend), .div_divisor_o(div_divisor),
    .div_flush_o(div_flush), .div_finish_i(div_finish), .div_out_i(div_out),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_tag_o(rsp_tag), .rsp_err_o(rsp_err), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // RISC-V divide semantics, including divide-by-zero and signed overflow.
  function automatic logic [63:0] rv_div(input logic [63:0] a, input logic [63:0] b,
                                         input logic uns, input logic rem);
    if (b == 64'd0) return rem ? a : '1;
    if (uns) return rem ? (a % b) : (a / b);
    if (a == 64'h8000_0000_0000_0000 && b == '1) return rem ? 64'd0 : a;
    return rem ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
  endfunction

  // Divider model: checks the issued packet, demands stable operands, finishes after div_lat.
  initial begin
    div_req_t cur;
    logic     pend;
    int       cd;
    pend = 1'b0;
    cd = 0;
    cur = '0;
    div_finish = 1'b0;
    div_out = '0;
    forever begin
      @(negedge clk);
      if (pend && !div_dp.valid) begin
        check("op_hold_dividend", div_dividend, cur.dividend);
        check("op_hold_divisor", div_divisor, cur.divisor);
      end
      if (div_dp.valid) begin
        if (issue_q.size() == 0) fail("unexpected_issue");
        else begin
          cur = issue_q.pop_front();
          check("issue_dividend", div_dividend, cur.dividend);
          check("issue_divisor", div_divisor, cur.divisor);
          check("issue_unsign", div_dp.unsign, cur.unsign);
          check("issue_rem", div_dp.rem, cur.rem);
          pend = (div_lat > 0);
          cd = div_lat;
        end
      end
      @(posedge clk); #1;
      div_finish = 1'b0;
      div_out = 64'hDEAD_BEEF_0BAD_F00D;
      if (pend) begin
        if (cd <= 1) begin
          div_finish = 1'b1;
          div_out = rv_div(cur.dividend, cur.divisor, cur.unsign, cur.rem);
          pend = 1'b0;
        end else cd--;
      end
    end
  end

  // Response monitor: pops the scoreboard on every accepted response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) fail("unexpected_rsp");
        else begin
          e = exp_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_tag", rsp_tag, e.tag);
          check("rsp_err", rsp_err, e.err);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic expect_rsp(input logic [63:0] data, input logic [4:0] tag, input logic err);
    exp_t e;
    e.data = data;
    e.tag = tag;
    e.err = err;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic uns,
                      input logic rem, input logic [4:0] tag, output int waits);
    div_req_t r;
    r = '{dividend: a, divisor: b, unsign: uns, rem: rem, tag: tag};
    issue_q.push_back(r);
    waits = 0;
    req_valid = 1'b1;
    req_dividend = a;
    req_divisor = b;
    req_unsign = uns;
    req_rem = rem;
    req_tag = tag;
    @(negedge clk);
    while (!req_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) fail("req_accept_timeout");
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int valid_cycles);
    int t;
    t = 0;
    valid_cycles = 0;
    @(negedge clk);
    while (busy && t < 400) begin
      if (div_dp.valid) valid_cycles++;
      @(negedge clk);
      t++;
    end
    if (t >= 400) fail(name);
    @(posedge clk); #1;
  endtask

  task automatic wait_for_rsp_valid(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail(name);
  endtask

  initial begin
    int w, vc, t, n_fl, fl_pos;
    rst = 1'b1;
    flush = 1'b0;
    req_valid = 1'b0;
    req_dividend = '0;
    req_divisor = '0;
    req_unsign = 1'b0;
    req_rem = 1'b0;
    req_tag = '0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_div_flush", div_flush, 1);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_div_valid", div_dp.valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_div_flush", div_flush, 0);
    check("post_rst_req_ready", req_ready, 1);
    @(posedge clk); #1;

    // 1: unsigned 2000/3 -> 666
    div_lat = 4;
    expect_rsp(64'h29a, 5'd4, 1'b0);
    send(64'h7d0, 64'h3, 1'b1, 1'b0, 5'd4, w);
    wait_idle("t1_idle", vc);
    check("t1_valid_cycles", vc, 1);
    check("t1_sb_empty", exp_q.size(), 0);

    // 2: signed -7 rem 2 = -1, then -7 / 2 = -3
    expect_rsp(64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 1'b0);
    expect_rsp(64'hFFFF_FFFF_FFFF_FFFD, 5'd2, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 1'b0, 1'b1, 5'd1, w);
    send(64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 1'b0, 1'b0, 5'd2, w);
    wait_idle("t2_idle", vc);
    check("t2_valid_cycles", vc, 2);
    check("t2_sb_empty", exp_q.size(), 0);

    // 3: three back-to-back requests into a 2-deep buffer, response held off
    div_lat = 6;
    rsp_ready = 1'b0;
    expect_rsp(64'he, 5'd10, 1'b0);
    expect_rsp(64'h2, 5'd11, 1'b0);
    expect_rsp(64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 1'b0);
    send(64'd100, 64'd7, 1'b1, 1'b0, 5'd10, w);
    send(64'd100, 64'd7, 1'b1, 1'b1, 5'd11, w);
    send(64'h40, 64'd0, 1'b1, 1'b0, 5'd12, w);
    check("t3_third_stalled", (w > 0), 1);
    @(negedge clk);
    check("t3_ready_low_full", req_ready, 0);
    check("t3_busy", busy, 1);
    wait_for_rsp_valid("t3_rsp_timeout");
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", rsp_valid, 1);
      check("t3_hold_data", rsp_data, 64'he);
      check("t3_hold_tag", rsp_tag, 10);
      check("t3_hold_err", rsp_err, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_idle("t3_idle", vc);
    check("t3_sb_empty", exp_q.size(), 0);

    // 4: flush in the cycle the divider finishes; queued request discarded too
    div_lat = 4;
    send(64'd50, 64'd5, 1'b1, 1'b0, 5'd20, w);
    send(64'd60, 64'd5, 1'b1, 1'b0, 5'd21, w);
    t = 0;
    @(negedge clk);
    while (!div_finish && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) fail("t4_finish_timeout");
    flush = 1'b1;
    #1;
    check("t4_div_flush", div_flush, 1);
    check("t4_ready_flush", req_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    issue_q.delete();
    @(negedge clk);
    check("t4_busy_after", busy, 0);
    check("t4_rsp_valid_after", rsp_valid, 0);
    check("t4_ready_after", req_ready, 1);
    repeat (6) @(negedge clk);
    check("t4_still_idle", busy, 0);
    @(posedge clk); #1;

    // 5: divider never finishes -> abort at WAIT cycle 16
    div_lat = 0;
    expect_rsp(64'h0, 5'd7, 1'b1);
    send(64'd5, 64'd1, 1'b1, 1'b0, 5'd7, w);
    t = 0;
    @(negedge clk);
    while (!div_dp.valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (t >= 10) fail("t5_issue_timeout");
    n_fl = 0;
    fl_pos = 0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (div_flush) begin
        n_fl++;
        fl_pos = k;
      end
    end
    check("t5_flush_pulses", n_fl, 1);
    check("t5_flush_cycle", fl_pos, 16);
    wait_idle("t5_idle", vc);
    check("t5_sb_empty", exp_q.size(), 0);

    // 6: reset during RESP drops the response; next request runs normally
    div_lat = 2;
    rsp_ready = 1'b0;
    send(64'd9, 64'd3, 1'b1, 1'b0, 5'd9, w);
    wait_for_rsp_valid("t6_rsp_timeout");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_rsp_valid", rsp_valid, 0);
    check("t6_rst_rsp_data", rsp_data, 0);
    check("t6_rst_rsp_tag", rsp_tag, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", req_ready, 0);
    check("t6_rst_dividend", div_dividend, 0);
    check("t6_rst_div_flush", div_flush, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t6_post_rsp_valid", rsp_valid, 0);
    check("t6_post_busy", busy, 0);
    check("t6_post_dividend", div_dividend, 0);
    @(posedge clk); #1;
    expect_rsp(64'ha, 5'd3, 1'b0);
    send(64'd100, 64'd10, 1'b0, 1'b0, 5'd3, w);
    wait_idle("t6_idle", vc);
    check("t6_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
